// File: rtl/spi_flash_resp.sv
// ============================================================================
// Module   : spi_flash_resp
// Brief    : SPI mode-0 flash target answering READ (03h), JEDEC ID (9Fh) and
//            READ STATUS (05h) from a synchronous byte-wide backing array.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_flash_resp #(
    parameter int          ADDR_W   = 24,
    parameter logic [23:0] JEDEC_ID = 24'hEF4018
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_i,
    input  logic              spi_sck_i,
    input  logic              spi_cs_n_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_oe_o,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_rdata_i,
    output logic              busy_o,
    output logic [7:0]        cmd_o,
    output logic              bad_cmd_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_DATA   = 3'd3,
        S_ID     = 3'd4,
        S_STAT   = 3'd5,
        S_IGNORE = 3'd6
    } state_t;

    state_t            r_state;
    logic [1:0]        r_sck_sync;
    logic [1:0]        r_cs_sync;
    logic [1:0]        r_mosi_sync;
    logic              r_sck_d;
    logic              r_cs_d;
    logic [1:0]        r_flush;
    logic              r_armed;
    logic [4:0]        r_bit_cnt;
    logic [23:0]       r_shift_in;
    logic [7:0]        r_shift_out;
    logic [7:0]        r_prefetch;
    logic [1:0]        r_byte_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rd_d;

    logic              w_sck;
    logic              w_cs_n;
    logic              w_mosi;
    logic              w_sck_rise;
    logic              w_sck_fall;
    logic              w_cs_fall;
    logic              w_cs_rise;
    logic [23:0]       w_shift_next;
    logic [ADDR_W-1:0] w_addr_inc;
    logic [7:0]        w_load_byte;

    assign w_sck        = r_sck_sync[1];
    assign w_cs_n       = r_cs_sync[1];
    assign w_mosi       = r_mosi_sync[1];
    assign w_sck_rise   = w_sck & ~r_sck_d;
    assign w_sck_fall   = ~w_sck & r_sck_d;
    assign w_cs_fall    = ~w_cs_n & r_cs_d;
    assign w_cs_rise    = w_cs_n & ~r_cs_d;
    assign w_shift_next = {r_shift_in[22:0], w_mosi};
    assign w_addr_inc   = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign busy_o       = ~w_cs_n;

    // Byte presented on MISO at each byte boundary, by active command.
    always_comb begin
        w_load_byte = 8'h00;
        if (r_state == S_DATA) begin
            w_load_byte = r_prefetch;
        end else if (r_state == S_ID) begin
            case (r_byte_cnt)
                2'd0:    w_load_byte = JEDEC_ID[23:16];
                2'd1:    w_load_byte = JEDEC_ID[15:8];
                2'd2:    w_load_byte = JEDEC_ID[7:0];
                default: w_load_byte = 8'h00;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_state       <= S_IDLE;
            r_sck_sync    <= 2'b00;
            r_cs_sync     <= 2'b11;
            r_mosi_sync   <= 2'b00;
            r_sck_d       <= 1'b0;
            r_cs_d        <= 1'b1;
            r_flush       <= 2'b00;
            r_armed       <= 1'b0;
            r_bit_cnt     <= 5'd0;
            r_shift_in    <= 24'd0;
            r_shift_out   <= 8'd0;
            r_prefetch    <= 8'd0;
            r_byte_cnt    <= 2'd0;
            r_addr        <= '0;
            r_rd_d        <= 1'b0;
            spi_miso_o    <= 1'b0;
            spi_miso_oe_o <= 1'b0;
            mem_rd_o      <= 1'b0;
            mem_addr_o    <= '0;
            cmd_o         <= 8'h00;
            bad_cmd_o     <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[0], spi_sck_i};
            r_cs_sync   <= {r_cs_sync[0], spi_cs_n_i};
            r_mosi_sync <= {r_mosi_sync[0], spi_mosi_i};
            r_sck_d     <= w_sck;
            r_cs_d      <= w_cs_n;
            // A CS window already open when reset lifted must close before
            // a new transfer is accepted; r_flush marks the synchronizer as
            // carrying real pin values rather than reset values.
            r_flush     <= {r_flush[0], 1'b1};
            if (r_flush[1] && w_cs_n) begin
                r_armed <= 1'b1;
            end

            mem_rd_o  <= 1'b0;
            bad_cmd_o <= 1'b0;
            r_rd_d    <= mem_rd_o;
            if (r_rd_d) begin
                r_prefetch <= mem_rdata_i;
            end

            if (w_cs_rise) begin
                r_state       <= S_IDLE;
                r_bit_cnt     <= 5'd0;
                r_shift_in    <= 24'd0;
                r_shift_out   <= 8'd0;
                r_byte_cnt    <= 2'd0;
                spi_miso_o    <= 1'b0;
                spi_miso_oe_o <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_cs_fall && r_armed) begin
                            r_state    <= S_CMD;
                            r_bit_cnt  <= 5'd0;
                            r_shift_in <= 24'd0;
                        end
                    end
                    S_CMD: begin
                        if (w_sck_rise) begin
                            r_shift_in <= w_shift_next;
                            if (r_bit_cnt == 5'd7) begin
                                r_bit_cnt  <= 5'd0;
                                r_byte_cnt <= 2'd0;
                                cmd_o      <= w_shift_next[7:0];
                                case (w_shift_next[7:0])
                                    8'h03: r_state <= S_ADDR;
                                    8'h9F: begin
                                        r_state       <= S_ID;
                                        spi_miso_oe_o <= 1'b1;
                                    end
                                    8'h05: begin
                                        r_state       <= S_STAT;
                                        spi_miso_oe_o <= 1'b1;
                                    end
                                    default: begin
                                        r_state   <= S_IGNORE;
                                        bad_cmd_o <= 1'b1;
                                    end
                                endcase
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (w_sck_rise) begin
                            r_shift_in <= w_shift_next;
                            if (r_bit_cnt == 5'd23) begin
                                r_bit_cnt     <= 5'd0;
                                r_addr        <= w_shift_next[ADDR_W-1:0];
                                mem_addr_o    <= w_shift_next[ADDR_W-1:0];
                                mem_rd_o      <= 1'b1;
                                spi_miso_oe_o <= 1'b1;
                                r_state       <= S_DATA;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 5'd1;
                            end
                        end
                    end
                    S_DATA, S_ID, S_STAT: begin
                        if (w_sck_rise) begin
                            r_bit_cnt <= (r_bit_cnt == 5'd7) ? 5'd0 : r_bit_cnt + 5'd1;
                            if (r_state == S_ID && r_bit_cnt == 5'd7 && r_byte_cnt != 2'd3) begin
                                r_byte_cnt <= r_byte_cnt + 2'd1;
                            end
                            // Fetch the following byte while this one shifts out.
                            if (r_state == S_DATA && r_bit_cnt == 5'd0) begin
                                r_addr     <= w_addr_inc;
                                mem_addr_o <= w_addr_inc;
                                mem_rd_o   <= 1'b1;
                            end
                        end else if (w_sck_fall) begin
                            if (r_bit_cnt == 5'd0) begin
                                spi_miso_o  <= w_load_byte[7];
                                r_shift_out <= {w_load_byte[6:0], 1'b0};
                            end else begin
                                spi_miso_o  <= r_shift_out[7];
                                r_shift_out <= {r_shift_out[6:0], 1'b0};
                            end
                        end
                    end
                    default: begin
                        spi_miso_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_flash_resp.sv
// ============================================================================
// Module   : tb_spi_flash_resp
// Brief    : Directed self-checking bench for spi_flash_resp.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_flash_resp;

    localparam int HALF = 80;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sck = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic        miso_oe;
    logic        mem_rd;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        busy;
    logic [7:0]  cmd;
    logic        bad_cmd;

    int vec_cnt = 0;
    int err_cnt = 0;
    int bad_pulses = 0;
    logic oe_seen = 1'b0;
    logic [23:0] rd_q[$];
    logic [7:0]  mem [logic [23:0]];

    spi_flash_resp #(.ADDR_W(24), .JEDEC_ID(24'hEF4018)) dut (
        .sys_clk_i     (clk),
        .sys_rst_i     (rst),
        .spi_sck_i     (sck),
        .spi_cs_n_i    (cs_n),
        .spi_mosi_i    (mosi),
        .spi_miso_o    (miso),
        .spi_miso_oe_o (miso_oe),
        .mem_rd_o      (mem_rd),
        .mem_addr_o    (mem_addr),
        .mem_rdata_i   (mem_rdata),
        .busy_o        (busy),
        .cmd_o         (cmd),
        .bad_cmd_o     (bad_cmd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
    end

    always @(negedge clk) begin
        if (mem_rd)  rd_q.push_back(mem_addr);
        if (bad_cmd) bad_pulses++;
        if (miso_oe) oe_seen = 1'b1;
    end

    task automatic spi_bits(input logic [23:0] tx, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = tx[i];
            #HALF sck = 1'b1;
            #HALF sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            mosi = tx[i];
            #HALF rx[i] = miso;
            sck = 1'b1;
            #HALF sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        #HALF;
    endtask

    task automatic cs_high();
        #HALF cs_n = 1'b1;
        #200;
    endtask

    task automatic clear_mon();
        rd_q.delete();
        bad_pulses = 0;
        oe_seen    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if ({miso, miso_oe, mem_rd, busy, bad_cmd} !== 5'b0) begin
            err_cnt++;
            $display("FAIL reset_flags: got %b exp 00000", {miso, miso_oe, mem_rd, busy, bad_cmd});
        end
        vec_cnt++;
        if (mem_addr !== 24'h0 || cmd !== 8'h00) begin
            err_cnt++;
            $display("FAIL reset_regs: addr %h cmd %h exp 000000 00", mem_addr, cmd);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #3;
    endtask

    task automatic test_read();
        logic [7:0] rx;
        logic [7:0] exp_b [3] = '{8'hA5, 8'h3C, 8'hF0};
        mem[24'h000100] = 8'hA5;
        mem[24'h000101] = 8'h3C;
        mem[24'h000102] = 8'hF0;
        clear_mon();
        cs_low();
        vec_cnt++;
        if (busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL read_busy: got %b exp 1", busy);
        end
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h01, rx);
        spi_byte(8'h00, rx);
        for (int i = 0; i < 3; i++) begin
            spi_byte(8'h00, rx);
            vec_cnt++;
            if (rx !== exp_b[i]) begin
                err_cnt++;
                $display("FAIL read_byte%0d: got %h exp %h", i, rx, exp_b[i]);
            end
        end
        cs_high();
        vec_cnt++;
        if (rd_q.size() < 3 || rd_q.size() > 4) begin
            err_cnt++;
            $display("FAIL read_rd_count: got %0d exp 3..4", rd_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vec_cnt++;
                if (rd_q[i] !== 24'h000100 + 24'(i)) begin
                    err_cnt++;
                    $display("FAIL read_addr%0d: got %h exp %h", i, rd_q[i], 24'h000100 + 24'(i));
                end
            end
        end
        vec_cnt++;
        if (busy !== 1'b0 || miso_oe !== 1'b0) begin
            err_cnt++;
            $display("FAIL read_idle: busy %b oe %b exp 0 0", busy, miso_oe);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] rx0, rx1, rx;
        mem[24'hFFFFFF] = 8'h11;
        mem[24'h000000] = 8'h22;
        clear_mon();
        cs_low();
        spi_byte(8'h03, rx);
        spi_byte(8'hFF, rx);
        spi_byte(8'hFF, rx);
        spi_byte(8'hFF, rx);
        spi_byte(8'h00, rx0);
        spi_byte(8'h00, rx1);
        cs_high();
        vec_cnt++;
        if (rx0 !== 8'h11 || rx1 !== 8'h22) begin
            err_cnt++;
            $display("FAIL wrap_data: got %h %h exp 11 22", rx0, rx1);
        end
        vec_cnt++;
        if (rd_q.size() < 2) begin
            err_cnt++;
            $display("FAIL wrap_rd_count: got %0d exp >=2", rd_q.size());
        end else if (rd_q[0] !== 24'hFFFFFF || rd_q[1] !== 24'h000000) begin
            err_cnt++;
            $display("FAIL wrap_addr: got %h %h exp ffffff 000000", rd_q[0], rd_q[1]);
        end
    endtask

    task automatic test_jedec();
        logic [7:0] rx;
        logic [7:0] exp_b [4] = '{8'hEF, 8'h40, 8'h18, 8'h00};
        clear_mon();
        cs_low();
        spi_byte(8'h9F, rx);
        for (int i = 0; i < 4; i++) begin
            spi_byte(8'h00, rx);
            vec_cnt++;
            if (rx !== exp_b[i]) begin
                err_cnt++;
                $display("FAIL jedec_byte%0d: got %h exp %h", i, rx, exp_b[i]);
            end
        end
        cs_high();
        vec_cnt++;
        if (cmd !== 8'h9F || oe_seen !== 1'b1) begin
            err_cnt++;
            $display("FAIL jedec_cmd_oe: cmd %h oe_seen %b exp 9f 1", cmd, oe_seen);
        end
    endtask

    task automatic test_bad_cmd();
        logic [7:0] rx;
        clear_mon();
        cs_low();
        spi_byte(8'h5A, rx);
        spi_byte(8'hFF, rx);
        cs_high();
        vec_cnt++;
        if (bad_pulses !== 1) begin
            err_cnt++;
            $display("FAIL bad_pulse: got %0d exp 1", bad_pulses);
        end
        vec_cnt++;
        if (oe_seen !== 1'b0 || rd_q.size() != 0 || rx !== 8'h00) begin
            err_cnt++;
            $display("FAIL bad_quiet: oe_seen %b rds %0d rx %h exp 0 0 00", oe_seen, rd_q.size(), rx);
        end
        vec_cnt++;
        if (cmd !== 8'h5A) begin
            err_cnt++;
            $display("FAIL bad_cmd_reg: got %h exp 5a", cmd);
        end
    endtask

    task automatic test_abort();
        logic [7:0] rx;
        clear_mon();
        cs_low();
        spi_byte(8'h03, rx);
        spi_bits(24'h000ABC, 12);
        cs_high();
        oe_seen = 1'b0;
        cs_low();
        spi_byte(8'h05, rx);
        spi_byte(8'h00, rx);
        vec_cnt++;
        if (rx !== 8'h00 || oe_seen !== 1'b1) begin
            err_cnt++;
            $display("FAIL abort_stat: rx %h oe_seen %b exp 00 1", rx, oe_seen);
        end
        cs_high();
        vec_cnt++;
        if (rd_q.size() != 0) begin
            err_cnt++;
            $display("FAIL abort_no_rd: got %0d reads exp 0", rd_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx;
        cs_low();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h01, rx);
        spi_byte(8'h00, rx);
        spi_bits(24'h0, 4);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if ({miso, miso_oe, mem_rd, busy, bad_cmd} !== 5'b0 || cmd !== 8'h00 || mem_addr !== 24'h0) begin
            err_cnt++;
            $display("FAIL midrst_vals: flags %b cmd %h addr %h exp 00000 00 000000",
                     {miso, miso_oe, mem_rd, busy, bad_cmd}, cmd, mem_addr);
        end
        rst = 1'b0;
        #3;
        clear_mon();
        spi_bits(24'h000000, 12);
        vec_cnt++;
        if (rd_q.size() != 0 || oe_seen !== 1'b0) begin
            err_cnt++;
            $display("FAIL midrst_ignore: reads %0d oe_seen %b exp 0 0", rd_q.size(), oe_seen);
        end
        cs_high();
        cs_low();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        cs_high();
        vec_cnt++;
        if (rx !== 8'h22) begin
            err_cnt++;
            $display("FAIL midrst_read0: got %h exp 22", rx);
        end
    endtask

    initial begin
        #3;
        test_reset();
        test_read();
        test_wrap();
        test_jedec();
        test_bad_cmd();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_flash_resp.md
SPI_FLASH_RESP -- requirements
Module: spi_flash_resp

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset; every flop, including the synchronizers, SHALL be clocked by sys_clk_i.
REQ-002 Parameter ADDR_W, default 24: flash address width; the SPI address phase is always 24 bits, and bits above ADDR_W are ignored.
REQ-003 Parameter JEDEC_ID, default 24'hEF4018: the three bytes returned by command 9Fh, MSB byte first.
REQ-004 Ports, in this order (name, direction, width, meaning):
- sys_clk_i  in  1  system clock.
- sys_rst_i  in  1  synchronous reset, active high.
- spi_sck_i  in  1  flash SCK from the master, SPI mode 0, asynchronous to sys_clk_i.
- spi_cs_n_i  in  1  chip select, active low.
- spi_mosi_i  in  1  serial data from the master.
- spi_miso_o  out  1  serial data to the master.
- spi_miso_oe_o  out  1  MISO output enable for the pad.
- mem_rd_o  out  1  one-cycle read strobe to the backing array.
- mem_addr_o  out  ADDR_W  read address.
- mem_rdata_i  in  8  read data, valid exactly 1 cycle after mem_rd_o.
- busy_o  out  1  high while CS is asserted.
- cmd_o  out  8  last opcode received.
- bad_cmd_o  out  1  one-cycle pulse when an unsupported opcode is received.

Function
REQ-005 SCK, CS_n and MOSI SHALL each pass through a 2-flop synchronizer; edges SHALL be detected from the synchronized values; the supported SCK rate is at most sys_clk_i/8.
REQ-006 MOSI SHALL be sampled on the detected SCK rising edge, MSB first; MISO SHALL change only on the detected SCK falling edge.
REQ-007 The state machine SHALL have the states IDLE, CMD, ADDR, DATA, ID, STAT and IGNORE.
REQ-008 IDLE -> CMD on the synchronized CS_n falling edge; this clears the bit counter.
REQ-009 CMD SHALL collect 8 bits, then load cmd_o and branch:
- 03h -> ADDR.
- 9Fh -> ID.
- 05h -> STAT.
- any other opcode -> IGNORE, with bad_cmd_o pulsed for one cycle.
REQ-010 ADDR SHALL collect 24 bits; on the cycle after the 24th rising edge it SHALL assert mem_rd_o with mem_addr_o equal to the collected address truncated to ADDR_W bits, then go to DATA.
REQ-011 In DATA, the first byte SHALL be loaded into the MISO shift register on the next SCK falling edge, so that bit 7 is valid before the next rising edge.
REQ-012 In DATA, on the first rising edge of each byte the block SHALL issue mem_rd_o for address+1, and capture mem_rdata_i into a prefetch register one cycle later.
REQ-013 In DATA, on the falling edge after the 8th bit of each byte, the shift register SHALL reload from the prefetch register; reads continue until CS rises.
REQ-014 The address increment SHALL wrap modulo 2^ADDR_W; for example, all-ones followed by a wrap reads address 0.
REQ-015 ID SHALL shift out JEDEC_ID[23:0], MSB first; after 24 bits, MISO SHALL output 0.
REQ-016 STAT SHALL shift out 00h, repeating for as long as CS stays low.
REQ-017 IGNORE SHALL hold MISO at 0, hold spi_miso_oe_o low, and ignore MOSI.
REQ-018 spi_miso_oe_o SHALL be high only in DATA, ID and STAT while CS_n is low.
REQ-019 A synchronized CS_n rising edge in any state SHALL return to IDLE on the next cycle.
- The bit counter and shift register clear; spi_miso_oe_o drops.
- Any partial byte is discarded, and no mem_rd_o is issued after that cycle.
REQ-020 A CS rise and an SCK edge detected in the same cycle: the CS rise wins and the SCK edge is ignored.
REQ-021 SCK edges detected while CS_n is high SHALL be ignored.
REQ-022 busy_o SHALL equal the inverted synchronized CS_n.
REQ-023 cmd_o SHALL hold its value until the next opcode completes.

Reset
REQ-024 While sys_rst_i is high, the block SHALL reset to:
- state IDLE.
- synchronizers to CS_n=1, SCK=0, MOSI=0.
- spi_miso_o=0, spi_miso_oe_o=0, mem_rd_o=0, mem_addr_o=0.
- busy_o=0, cmd_o=00h, bad_cmd_o=0.
- counters and shift registers 0.
REQ-025 Reset asserted mid-transfer SHALL abort the transfer; after reset is released, the block SHALL ignore the remainder of that CS window until CS_n is sampled high.

Verification
REQ-026 READ: CS low, send 03h 00h 01h 00h, array[0x100..0x102]=A5h,3Ch,F0h, clock 24 more bits -> MISO returns A5h 3Ch F0h; mem_rd_o pulses 3-4 times with addresses 100h,101h,102h(,103h).
REQ-027 Wrap: READ at FFFFFFh with array[FFFFFFh]=11h and array[0]=22h -> MISO returns 11h then 22h; the second mem_addr_o is 0.
REQ-028 JEDEC: send 9Fh, then clock 32 bits -> MISO returns EFh 40h 18h 00h; cmd_o=9Fh.
REQ-029 Bad opcode: send 5Ah -> bad_cmd_o pulses once, spi_miso_oe_o stays 0, and no mem_rd_o occurs.
REQ-030 Abort: raise CS after 12 address bits, then send 05h -> no mem_rd_o is issued, and the status read returns 00h with spi_miso_oe_o=1.
REQ-031 Reset: assert sys_rst_i during DATA, release it, then run a READ at 000000h -> all outputs are at their reset values during reset, and the new READ returns array[0].
